// File: rtl/fft_stage_sequencer_if.sv
// Control bundle between the FFT stage sequencer and its datapath/neighbours.
// master = sequencer side, slave = deserializer/butterfly/serializer side.
interface fft_stage_sequencer_if #(
  parameter int SIZE_FFT  = 8,
  parameter int CNT_WIDTH = 8
);
  localparam int STAGE_W = $clog2($clog2(SIZE_FFT) + 1);

  logic                 recv_val;
  logic                 recv_rdy;
  logic                 send_val;
  logic                 send_rdy;
  logic                 buf_load;
  logic [STAGE_W-1:0]   stage;
  logic                 bfly_start;
  logic                 bfly_done;
  logic                 buf_swap;
  logic                 busy;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic                 err;

  modport master (
    input  recv_val, send_rdy, bfly_done,
    output recv_rdy, send_val, buf_load, stage, bfly_start, buf_swap, busy, frame_cnt, err
  );

  modport slave (
    output recv_val, send_rdy, bfly_done,
    input  recv_rdy, send_val, buf_load, stage, bfly_start, buf_swap, busy, frame_cnt, err
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an iterative FFT: load, per-stage start/wait/swap, hand off frame.
// Latency: 2 + $clog2(SIZE_FFT)*(2+wait) cycles from accept to send_val; Moore outputs.
// Backpressure: holds send_val in DONE until send_rdy; recv_rdy only in IDLE. Option: FFT_SEQ_TIMEOUT_EN.
module fft_stage_sequencer #(
  parameter int SIZE_FFT       = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fft_stage_sequencer_if.master bus
);

  localparam int NUM_STAGES = $clog2(SIZE_FFT);
  localparam int STAGE_W    = $clog2(NUM_STAGES + 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]           state_q,     state_d;
  logic [STAGE_W-1:0]   stage_q,     stage_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                 err_q,       err_d;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Counts WAIT cycles already spent without bfly_done.
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
`ifdef FFT_SEQ_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.recv_val) begin
          state_d = ST_LOAD;
          stage_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef FFT_SEQ_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.bfly_done) begin
          state_d = ST_WB;
`ifdef FFT_SEQ_TIMEOUT_EN
        end else if (wdog_q == WD_LAST) begin
          state_d = ST_IDLE;
          stage_d = '0;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 1'b1;
`endif
        end
      end
      ST_WB: begin
        if (stage_q == LAST_STAGE) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 1'b1;
          state_d = ST_START;
        end
      end
      ST_DONE: begin
        if (bus.send_rdy) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          stage_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        stage_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef FFT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.recv_rdy   = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.buf_load   = (state_q == ST_LOAD);
  assign bus.bfly_start = (state_q == ST_START);
  assign bus.buf_swap   = (state_q == ST_WB);
  assign bus.send_val   = (state_q == ST_DONE);
  assign bus.stage      = stage_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: frame tasks queue expected control pulses; a monitor pops and compares them.
module tb_fft_stage_sequencer;
  localparam int SIZE_FFT       = 8;
  localparam int CNT_WIDTH      = 2;
  localparam int TIMEOUT_CYCLES = 4;
  localparam int NS             = 3;
  localparam int CNT_MOD        = 4;

  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_SWAP  = 2;
  localparam int K_SEND  = 3;

  logic clk = 1'b0;
  logic reset_n;

  fft_stage_sequencer_if #(.SIZE_FFT(SIZE_FFT), .CNT_WIDTH(CNT_WIDTH)) bus_if ();

  fft_stage_sequencer #(
    .SIZE_FFT      (SIZE_FFT),
    .CNT_WIDTH     (CNT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    int stg;
    int fcnt;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  fc      = 0;
  int  mode    = 0;     // 0: bfly_done tied high, 1: done 5 cycles after start, 2: never
  int  done_on = -100;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push_ev(input int c, input int k, input int s);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.stg  = s;
    e.fcnt = fc;
    exp_q.push_back(e);
  endtask

  // Butterfly model; in slow mode bfly_done also stays high through WB as a stray pulse.
  always @(negedge clk) begin
    case (mode)
      0: bus_if.bfly_done = 1'b1;
      1: begin
        if (bus_if.bfly_start) done_on = cyc + 5;
        bus_if.bfly_done = (cyc >= done_on) && (cyc <= done_on + 1);
      end
      default: bus_if.bfly_done = 1'b0;
    endcase
  end

  int   mon_kind;
  ev_t  mon_e;
  always begin
    @(negedge clk);
    #1;
    if (reset_n === 1'b1) begin
      mon_kind = -1;
      if (bus_if.buf_load)                           mon_kind = K_LOAD;
      else if (bus_if.bfly_start)                    mon_kind = K_START;
      else if (bus_if.buf_swap)                      mon_kind = K_SWAP;
      else if (bus_if.send_val && bus_if.send_rdy)   mon_kind = K_SEND;
      if (mon_kind >= 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          n_total++;
          if (cyc == mon_e.cyc && mon_kind == mon_e.kind && int'(bus_if.stage) == mon_e.stg &&
              int'(bus_if.frame_cnt) == mon_e.fcnt && bus_if.busy == 1'b1)
            n_pass++;
          else
            $display("FAIL event: got cyc=%0d kind=%0d stage=%0d cnt=%0d busy=%0b, expected cyc=%0d kind=%0d stage=%0d cnt=%0d busy=1",
                     cyc, mon_kind, bus_if.stage, bus_if.frame_cnt, bus_if.busy,
                     mon_e.cyc, mon_e.kind, mon_e.stg, mon_e.fcnt);
        end
      end
    end
  end

  task automatic run_frame(input int mode_i, input int bp);
    int a, p, dn, h;
    p = (mode_i == 1) ? 7 : 3;
    check("recv_rdy_idle", int'(bus_if.recv_rdy), 1);
    check("busy_idle", int'(bus_if.busy), 0);
    mode = mode_i;
    bus_if.recv_val = 1'b1;
    a  = cyc;
    dn = a + 2 + NS * p;
    h  = dn + bp;
    push_ev(a + 1, K_LOAD, 0);
    for (int s = 0; s < NS; s++) begin
      push_ev(a + 2 + s * p, K_START, s);
      push_ev(a + 1 + (s + 1) * p, K_SWAP, s);
    end
    push_ev(h, K_SEND, NS - 1);
    if (bp > 0) bus_if.send_rdy = 1'b0;
    @(negedge clk);
    bus_if.recv_val = 1'b0;
    if (bp > 0) begin
      wait_until(dn);
      for (int i = 0; i < bp; i++) begin
        check("bp_send_val", int'(bus_if.send_val), 1);
        check("bp_recv_rdy", int'(bus_if.recv_rdy), 0);
        bus_if.recv_val = 1'b1;
        @(negedge clk);
      end
      bus_if.recv_val = 1'b0;
      bus_if.send_rdy = 1'b1;
    end
    wait_until(h + 1);
    fc = (fc + 1) % CNT_MOD;
    check("frame_cnt", int'(bus_if.frame_cnt), fc);
    check("stage_after_send", int'(bus_if.stage), 0);
  endtask

  initial begin
    int a;
    reset_n         = 1'b0;
    bus_if.recv_val = 1'b0;
    bus_if.send_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_recv_rdy", int'(bus_if.recv_rdy), 1);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_send_val", int'(bus_if.send_val), 0);
    check("rst_frame_cnt", int'(bus_if.frame_cnt), 0);
    check("rst_stage", int'(bus_if.stage), 0);
    check("rst_err", int'(bus_if.err), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(0, 0);

    // Abort a frame with reset while the butterfly is still busy.
    mode = 1;
    bus_if.recv_val = 1'b1;
    a = cyc;
    push_ev(a + 1, K_LOAD, 0);
    push_ev(a + 2, K_START, 0);
    @(negedge clk);
    bus_if.recv_val = 1'b0;
    wait_until(a + 4);
    check("pre_reset_busy", int'(bus_if.busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_recv_rdy", int'(bus_if.recv_rdy), 1);
    check("midrst_busy", int'(bus_if.busy), 0);
    check("midrst_pulses", int'({bus_if.buf_load, bus_if.bfly_start, bus_if.buf_swap, bus_if.send_val}), 0);
    check("midrst_frame_cnt", int'(bus_if.frame_cnt), 0);
    check("midrst_stage", int'(bus_if.stage), 0);
    check("midrst_sb_empty", exp_q.size(), 0);
    fc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    mode = 0;
    @(negedge clk);

    for (int f = 0; f < 5; f++) run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 10);

`ifdef FFT_SEQ_TIMEOUT_EN
    mode = 2;
    bus_if.recv_val = 1'b1;
    a = cyc;
    push_ev(a + 1, K_LOAD, 0);
    push_ev(a + 2, K_START, 0);
    @(negedge clk);
    bus_if.recv_val = 1'b0;
    wait_until(a + 6);
    check("to_err_before", int'(bus_if.err), 0);
    check("to_busy_before", int'(bus_if.busy), 1);
    wait_until(a + 7);
    check("to_err", int'(bus_if.err), 1);
    check("to_recv_rdy", int'(bus_if.recv_rdy), 1);
    check("to_stage", int'(bus_if.stage), 0);
    check("to_frame_cnt", int'(bus_if.frame_cnt), fc);
    run_frame(0, 0);
    check("to_err_sticky", int'(bus_if.err), 1);
`else
    check("err_tied_low", int'(bus_if.err), 0);
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
